// File: rtl/tile_field_renderer.sv
// rtl/tile_field_renderer.sv - playfield/preview compositor with line-clear flash FSM
// Optional macro TILE_GRID_EN draws 12'h333 grid lines on empty playfield cells.
module tile_field_renderer #(
    parameter int          GRID_W       = 10,
    parameter int          GRID_H       = 20,
    parameter int          TILE         = 14,
    parameter int          ORG_X        = 208,
    parameter int          ORG_Y        = 105,
    parameter int          PRV_X        = 368,
    parameter int          PRV_Y        = 279,
    parameter int          FLASH_FRAMES = 8,
    parameter int          FLASH_PHASES = 6,
    parameter logic [11:0] FLASH_RGB    = 12'hCCC
) (
    input  logic                            clk,
    input  logic                            clrn,
    input  logic [8:0]                      row_addr,
    input  logic [9:0]                      col_addr,
    input  logic                            frame_start,
    input  logic [GRID_W*GRID_H-1:0]        field,
    input  logic [2:0]                      nextblock,
    input  logic                            flash_req,
    input  logic [GRID_H-1:0]               flash_rows,
    output logic [18:0]                     bg_addr,
    output logic [$clog2(TILE*TILE)-1:0]    tile_addr,
    input  logic [11:0]                     bg_data,
    input  logic [11:0]                     tile_data,
    output logic [11:0]                     pix_out,
    output logic                            flash_busy,
    output logic                            flash_done
);
    localparam int SW  = $clog2(TILE);
    localparam int TAW = $clog2(TILE*TILE);
    localparam int FIW = $clog2(GRID_W*GRID_H);
    localparam int RW  = $clog2(GRID_H);
    localparam int FCW = $clog2(FLASH_FRAMES+1);
    localparam int PHW = $clog2(FLASH_PHASES+1);
    localparam logic [SW-1:0] SUB_MAX = SW'(TILE-1);
    localparam logic [9:0] FX0 = 10'(ORG_X);
    localparam logic [9:0] FX1 = 10'(ORG_X+GRID_W*TILE-1);
    localparam logic [9:0] PX0 = 10'(PRV_X);
    localparam logic [9:0] PX1 = 10'(PRV_X+4*TILE-1);
    localparam logic [8:0] FY0 = 9'(ORG_Y);
    localparam logic [8:0] FY1 = 9'(ORG_Y+GRID_H*TILE-1);
    localparam logic [8:0] PY0 = 9'(PRV_Y);
    localparam logic [8:0] PY1 = 9'(PRV_Y+2*TILE-1);

    typedef enum logic [1:0] {S_IDLE, S_FLASH, S_DONE} state_t;

    state_t             r_state;
    logic [GRID_H-1:0]  r_mask;
    logic [FCW-1:0]     r_frame_cnt;
    logic [PHW-1:0]     r_phase;
    logic               r_flash_on, r_busy, r_done;
    logic [8:0]         r_prev_row;
    logic [SW-1:0]      r_fx_sub, r_fy_sub, r_px_sub, r_py_sub;
    logic [9:0]         r_fx_col, r_fy_row, r_px_col, r_py_row;
    logic               r_in_field, r_cell, r_prv_hit, r_flash_hit, r_grid;
    logic [11:0]        r_pix;

    logic [SW-1:0]      w_fx_sub, w_fy_sub, w_px_sub, w_py_sub;
    logic [9:0]         w_fx_col, w_fy_row, w_px_col, w_py_row;
    logic               w_in_field, w_in_prv, w_row_chg;
    logic [FIW-1:0]     w_fidx;
    logic [RW-1:0]      w_mrow;
    logic [2:0]         w_pidx;
    logic [7:0]         w_shape;
    logic [11:0]        w_pix;

    // Returns {tile, sub} after one step: reload at the origin, else count with wrap.
    function automatic logic [SW+9:0] adv(input logic reload, input logic [9:0] t,
                                          input logic [SW-1:0] s);
        if (reload)            return '0;
        else if (s == SUB_MAX) return {t + 10'd1, {SW{1'b0}}};
        else                   return {t, s + SW'(1)};
    endfunction

    always_comb begin
        {w_fx_col, w_fx_sub} = adv(col_addr == FX0, r_fx_col, r_fx_sub);
        {w_px_col, w_px_sub} = adv(col_addr == PX0, r_px_col, r_px_sub);
        w_row_chg = (row_addr != r_prev_row);
        {w_fy_row, w_fy_sub} = {r_fy_row, r_fy_sub};
        {w_py_row, w_py_sub} = {r_py_row, r_py_sub};
        if (w_row_chg) begin
            {w_fy_row, w_fy_sub} = adv(row_addr == FY0, r_fy_row, r_fy_sub);
            {w_py_row, w_py_sub} = adv(row_addr == PY0, r_py_row, r_py_sub);
        end
        w_in_field = (col_addr >= FX0) && (col_addr <= FX1) && (row_addr >= FY0) && (row_addr <= FY1);
        w_in_prv   = (col_addr >= PX0) && (col_addr <= PX1) && (row_addr >= PY0) && (row_addr <= PY1);
        w_fidx = FIW'(int'(w_fy_row) * GRID_W + int'(w_fx_col));
        w_mrow = RW'(w_fy_row);
        w_pidx = 3'({w_py_row, 2'b00} + w_px_col);
        case (nextblock)
            3'd0:    w_shape = 8'b1111_0000;
            3'd1:    w_shape = 8'b0011_0011;
            3'd2:    w_shape = 8'b0111_0010;
            3'd3:    w_shape = 8'b0111_0100;
            3'd4:    w_shape = 8'b0110_0011;
            default: w_shape = 8'b0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_prev_row <= '0;
            r_fx_sub <= '0; r_fx_col <= '0; r_fy_sub <= '0; r_fy_row <= '0;
            r_px_sub <= '0; r_px_col <= '0; r_py_sub <= '0; r_py_row <= '0;
            r_in_field <= 1'b0; r_cell <= 1'b0; r_prv_hit <= 1'b0;
            r_flash_hit <= 1'b0; r_grid <= 1'b0;
            bg_addr <= '0; tile_addr <= '0; r_pix <= '0;
        end else begin
            r_prev_row <= row_addr;
            r_fx_sub <= w_fx_sub; r_fx_col <= w_fx_col; r_fy_sub <= w_fy_sub; r_fy_row <= w_fy_row;
            r_px_sub <= w_px_sub; r_px_col <= w_px_col; r_py_sub <= w_py_sub; r_py_row <= w_py_row;
            r_in_field  <= w_in_field;
            r_cell      <= w_in_field && field[w_fidx];
            r_prv_hit   <= w_in_prv && w_shape[w_pidx];
            r_flash_hit <= w_in_field && r_flash_on && r_mask[w_mrow];
            r_grid      <= (w_fx_sub == '0) || (w_fy_sub == '0);
            bg_addr <= 19'(row_addr) * 19'd640 + 19'(col_addr);
            tile_addr <= w_in_prv ? TAW'(int'(w_py_sub) * TILE + int'(w_px_sub))
                                  : TAW'(int'(w_fy_sub) * TILE + int'(w_fx_sub));
            r_pix <= w_pix;
        end
    end

    always_comb begin
        w_pix = bg_data;
        if (r_prv_hit)                       w_pix = tile_data;
        else if (r_in_field && r_flash_hit)  w_pix = FLASH_RGB;
        else if (r_in_field && r_cell)       w_pix = tile_data;
`ifdef TILE_GRID_EN
        else if (r_in_field && r_grid)       w_pix = 12'h333;
`endif
    end

    // Flash sequencer: phases advance on frame_start boundaries only.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE; r_mask <= '0; r_frame_cnt <= '0; r_phase <= '0;
            r_flash_on <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (flash_req) begin
                    r_mask <= flash_rows; r_phase <= '0; r_frame_cnt <= '0;
                    r_flash_on <= 1'b1; r_busy <= 1'b1; r_state <= S_FLASH;
                end
                S_FLASH: if (frame_start) begin
                    if (r_frame_cnt == FCW'(FLASH_FRAMES-1)) begin
                        r_frame_cnt <= '0;
                        if (r_phase == PHW'(FLASH_PHASES-1)) begin
                            r_flash_on <= 1'b0; r_done <= 1'b1; r_state <= S_DONE;
                        end else begin
                            r_phase <= r_phase + PHW'(1); r_flash_on <= ~r_flash_on;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FCW'(1);
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0; r_busy <= 1'b0; r_mask <= '0; r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_out    = r_pix;
    assign flash_busy = r_busy;
    assign flash_done = r_done;
endmodule

// File: tb/tb_tile_field_renderer.sv
// tb/tb_tile_field_renderer.sv - bench for tile_field_renderer against an arithmetic screen model
module tb_tile_field_renderer;
    localparam int GRID_W = 10, GRID_H = 20, TILE = 14;
    localparam int ORG_X = 208, ORG_Y = 105, PRV_X = 368, PRV_Y = 279;
    localparam logic [11:0] FLASH_RGB = 12'hCCC;
    localparam int TAW = $clog2(TILE*TILE);

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic                     clrn = 1'b0;
    logic [8:0]               row_addr = '0;
    logic [9:0]               col_addr = '0;
    logic                     frame_start = 1'b0, flash_req = 1'b0;
    logic [GRID_W*GRID_H-1:0] field = '0;
    logic [2:0]               nextblock = 3'd7;
    logic [GRID_H-1:0]        flash_rows = '0;
    logic [18:0]              bg_addr;
    logic [TAW-1:0]           tile_addr;
    logic [11:0]              bg_data, tile_data, pix_out;
    logic                     flash_busy, flash_done;

    tile_field_renderer dut (
        .clk(clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr),
        .frame_start(frame_start), .field(field), .nextblock(nextblock),
        .flash_req(flash_req), .flash_rows(flash_rows), .bg_addr(bg_addr),
        .tile_addr(tile_addr), .bg_data(bg_data), .tile_data(tile_data),
        .pix_out(pix_out), .flash_busy(flash_busy), .flash_done(flash_done)
    );

    function automatic logic [11:0] bg_rom(input int a);
        logic [18:0] v;
        v = 19'(a);
        return v[11:0] ^ v[18:7] ^ 12'h5A5;
    endfunction
    assign bg_data   = bg_rom(int'(bg_addr));
    assign tile_data = {4'h9, tile_addr};

    int total = 0, bad = 0, n_done = 0;
    logic [GRID_H-1:0] exp_mask = '0;
    bit exp_on = 1'b0;
    int shapes [5][4] = '{'{4,5,6,7}, '{0,1,4,5}, '{1,4,5,6}, '{2,4,5,6}, '{0,1,5,6}};

    always @(negedge clk) if (flash_done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Screen model from pixel coordinates using division and shape lists.
    task automatic model(input int r, input int c, output logic [11:0] pix, output int ta, output bit inreg);
        int fr, fc, pr, pc, idx;
        bit in_f, in_p, occ;
        fr = r - ORG_Y; fc = c - ORG_X; pr = r - PRV_Y; pc = c - PRV_X;
        in_f = fr >= 0 && fr < GRID_H*TILE && fc >= 0 && fc < GRID_W*TILE;
        in_p = pr >= 0 && pr < 2*TILE && pc >= 0 && pc < 4*TILE;
        occ = 1'b0;
        if (in_p && nextblock <= 3'd4) begin
            idx = (pr / TILE) * 4 + pc / TILE;
            for (int k = 0; k < 4; k++) if (shapes[nextblock][k] == idx) occ = 1'b1;
        end
        inreg = in_f || in_p;
        ta = in_p ? (pr % TILE) * TILE + pc % TILE : (fr % TILE) * TILE + fc % TILE;
        pix = bg_rom(640*r + c);
        if (in_p && occ) pix = {4'h9, 8'(ta)};
        else if (in_f && exp_on && exp_mask[fr / TILE]) pix = FLASH_RGB;
        else if (in_f && field[(fr / TILE) * GRID_W + fc / TILE]) pix = {4'h9, 8'(ta)};
`ifdef TILE_GRID_EN
        else if (in_f && (fr % TILE == 0 || fc % TILE == 0)) pix = 12'h333;
`endif
    endtask

    task automatic walk(input int r0, input int r1);
        for (int r = r0; r <= r1; r++) begin
            row_addr = 9'(r); col_addr = '0; tick();
        end
    endtask

    task automatic scan(input int r, input int c0, input int c1);
        logic [11:0] pend, p;
        int ta;
        bit inreg, have;
        have = 1'b0; pend = '0;
        for (int c = c0; c <= c1 + 1; c++) begin
            row_addr = 9'(r); col_addr = 10'(c);
            tick();
            if (have) check($sformatf("pix r%0d c%0d", r, c - 1), pix_out, pend);
            if (c <= c1) begin
                model(r, c, p, ta, inreg);
                check("bg_addr", bg_addr, 640*r + c);
                if (inreg) check($sformatf("tile_addr r%0d c%0d", r, c), tile_addr, ta);
                pend = p; have = 1'b1;
            end
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("rst_pix", pix_out, 0);
        check("rst_bg_addr", bg_addr, 0);
        check("rst_tile_addr", tile_addr, 0);
        check("rst_busy", flash_busy, 0);
        check("rst_done", flash_done, 0);
        clrn = 1'b1; tick();

        // Single occupied cell in the top-left corner.
        field = '0; field[0] = 1'b1; nextblock = 3'd7;
        walk(104, 104);
        scan(105, 206, 224);

        // Random field with the bottom-right cell occupied.
        for (int i = 0; i < GRID_W*GRID_H; i++) field[i] = 1'($urandom_range(0, 1));
        field[199] = 1'b1;
        walk(106, 109); scan(110, 206, 349);
        walk(111, 199); scan(200, 206, 349);
        walk(201, 382); scan(383, 206, 349); scan(384, 206, 349); scan(385, 206, 230);

        // Preview area: fixed piece, random pieces, empty code.
        nextblock = 3'd2;
        walk(104, 278); scan(279, 366, 426);
        walk(280, 292); scan(293, 366, 426);
        nextblock = 3'($urandom_range(0, 4)); scan(294, 366, 426);
        nextblock = 3'd7; scan(295, 366, 426);
        nextblock = 3'($urandom_range(0, 7)); walk(296, 300); scan(301, 366, 426);
        nextblock = 3'd7;

        // Full flash sequence on row 19; request coincides with a frame_start.
        walk(104, 370);
        flash_rows = 20'h80000;
        flash_req = 1'b1; frame_start = 1'b1; tick();
        flash_req = 1'b0; frame_start = 1'b0;
        exp_mask = 20'h80000; exp_on = 1'b1;
        check("busy_rise", flash_busy, 1);
        check("done_low", flash_done, 0);
        scan(371, 206, 240);
        for (int f = 1; f <= 48; f++) begin
            frame_pulse();
            if (f == 48) begin
                check("done_pulse", flash_done, 1);
                check("busy_in_done", flash_busy, 1);
                tick();
                exp_mask = '0; exp_on = 1'b0;
                check("done_fall", flash_done, 0);
                check("busy_fall", flash_busy, 0);
            end else begin
                exp_on = ((f / 8) % 2) == 0;
                check($sformatf("busy_f%0d", f), flash_busy, 1);
                check($sformatf("done_f%0d", f), flash_done, 0);
                if (f == 17) begin
                    flash_rows = ~20'h80000; flash_req = 1'b1; tick(); flash_req = 1'b0;
                    walk(104, 369); scan(370, 206, 240);
                end
                scan(371, 206, 240);
            end
        end
        scan(371, 206, 240);
        check("done_count_1", n_done, 1);

        // Abort by reset at frame 20.
        flash_rows = 20'($urandom); flash_req = 1'b1; tick(); flash_req = 1'b0;
        for (int f = 1; f <= 20; f++) frame_pulse();
        check("busy_before_abort", flash_busy, 1);
        clrn = 1'b0; #1;
        check("abort_busy", flash_busy, 0);
        check("abort_done", flash_done, 0);
        check("abort_pix", pix_out, 0);
        tick(); clrn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", n_done, 1);
        check("abort_busy_idle", flash_busy, 0);

        // All-zero mask still runs the whole sequence without recolouring.
        walk(104, 370);
        flash_rows = '0; flash_req = 1'b1; tick(); flash_req = 1'b0;
        exp_mask = '0; exp_on = 1'b1;
        scan(371, 206, 240);
        for (int f = 1; f <= 47; f++) frame_pulse();
        check("zero_busy", flash_busy, 1);
        frame_pulse();
        check("zero_done", flash_done, 1);
        tick();
        check("done_count_2", n_done, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
